// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 bus monitor.
package hub75_pkg;

   localparam int unsigned PIX_W = 6;

   // Bit positions inside one pixel word {r0,r1,g0,g1,b0,b1}
   localparam int unsigned R0_BIT = 5;
   localparam int unsigned R1_BIT = 4;
   localparam int unsigned G0_BIT = 3;
   localparam int unsigned G1_BIT = 2;
   localparam int unsigned B0_BIT = 1;
   localparam int unsigned B1_BIT = 0;

   typedef logic [PIX_W-1:0] pixel_t;

   // Pack individual colour lines into a pixel word
   function automatic pixel_t make_pixel(input logic r0, input logic r1,
                                         input logic g0, input logic g1,
                                         input logic b0, input logic b1);
      pixel_t p;
      p         = '0;
      p[R0_BIT] = r0;
      p[R1_BIT] = r1;
      p[G0_BIT] = g0;
      p[G1_BIT] = g1;
      p[B0_BIT] = b0;
      p[B1_BIT] = b1;
      return p;
   endfunction

endpackage

// File: rtl/rise_detect.sv
// W-bit rising-edge detector on sampled (non-clock) inputs.
// The first cycle after reset release only arms the detector, so an input
// already high when reset lifts never reports an edge.
module rise_detect #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] rise_c
);

   logic [W-1:0] prev_q, prev_d;
   logic         armed_q, armed_d;

   // Next state: remember the current sample and arm after one cycle
   always_comb begin
      prev_d  = d;
      armed_d = 1'b1;
   end

   // Edge history registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q  <= '0;
         armed_q <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         armed_q <= armed_d;
      end
   end

   // Edge output, suppressed until armed
   always_comb begin
      rise_c = '0;
      if (armed_q) rise_c = d & ~prev_q;
   end

endmodule

// File: rtl/hub75_row_monitor.sv
// HUB75 panel bus snooper: shifts pixels on SCLK, commits a row on LAT,
// flags protocol errors and exposes the committed row for random reads.
module hub75_row_monitor
   import hub75_pkg::*;
#(
   parameter int unsigned COLS        = 64,
   parameter int unsigned ROW_ADDR_W  = 5,
   parameter int unsigned FRAME_CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     nreset,
   input  logic                     sclk,
   input  logic                     lat,
   input  logic                     oe_n,
   input  logic [ROW_ADDR_W-1:0]    addr,
   input  logic [PIX_W-1:0]         rgb,
   input  logic [$clog2(COLS)-1:0]  rd_col,
   output logic [PIX_W-1:0]         rd_pixel,
   output logic                     row_valid,
   output logic [ROW_ADDR_W-1:0]    row_addr,
   output logic                     frame_done,
   output logic [FRAME_CNT_W-1:0]   frame_count,
   output logic                     err_short,
   output logic                     err_overrun,
   output logic                     err_oe
);

   localparam int unsigned COL_W = $clog2(COLS);
   localparam int unsigned CNT_W = $clog2(COLS + 2);
   localparam logic [ROW_ADDR_W-1:0] LAST_ROW = '1;

   logic [1:0] rise_c;
   logic       sclk_rise;
   logic       lat_rise;

   pixel_t shift_q [COLS];
   pixel_t shift_d [COLS];
   pixel_t store_q [COLS];
   pixel_t store_d [COLS];

   logic [CNT_W-1:0]       col_cnt_q, col_cnt_d, cnt_post;
   logic                   row_valid_q, row_valid_d;
   logic [ROW_ADDR_W-1:0]  row_addr_q, row_addr_d;
   logic [ROW_ADDR_W-1:0]  last_addr_q, last_addr_d;
   logic                   frame_done_q, frame_done_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic                   err_short_q, err_short_d;
   logic                   err_overrun_q, err_overrun_d;
   logic                   err_oe_q, err_oe_d;
   logic [COL_W-1:0]       rd_idx;

   rise_detect #(.W(2)) u_rise (
      .clk    (clk),
      .rst_n  (nreset),
      .d      ({lat, sclk}),
      .rise_c (rise_c)
   );

   assign sclk_rise = rise_c[0];
   assign lat_rise  = rise_c[1];

   // Shift, commit and protocol checking; shift is applied before commit
   always_comb begin
      shift_d       = shift_q;
      store_d       = store_q;
      col_cnt_d     = col_cnt_q;
      row_valid_d   = 1'b0;
      row_addr_d    = row_addr_q;
      last_addr_d   = last_addr_q;
      frame_done_d  = 1'b0;
      frame_cnt_d   = frame_cnt_q;
      err_short_d   = err_short_q;
      err_overrun_d = err_overrun_q;
      err_oe_d      = err_oe_q;
      cnt_post      = col_cnt_q;

      if (sclk_rise) begin
         shift_d[0] = rgb;
         for (int i = 1; i < COLS; i++) shift_d[i] = shift_q[i-1];
         if (col_cnt_q == CNT_W'(COLS)) err_overrun_d = 1'b1;
         if (col_cnt_q != CNT_W'(COLS + 1)) cnt_post = col_cnt_q + CNT_W'(1);
      end
      col_cnt_d = cnt_post;

      if (lat_rise) begin
         store_d     = shift_d;
         row_addr_d  = addr;
         row_valid_d = 1'b1;
         col_cnt_d   = '0;
         if (cnt_post != CNT_W'(COLS)) err_short_d = 1'b1;
         if (!oe_n) err_oe_d = 1'b1;
         if (addr == '0 && last_addr_q == LAST_ROW) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
         end
         last_addr_d = addr;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < COLS; i++) begin
            shift_q[i] <= '0;
            store_q[i] <= '0;
         end
         col_cnt_q     <= '0;
         row_valid_q   <= 1'b0;
         row_addr_q    <= '0;
         last_addr_q   <= LAST_ROW;
         frame_done_q  <= 1'b0;
         frame_cnt_q   <= '0;
         err_short_q   <= 1'b0;
         err_overrun_q <= 1'b0;
         err_oe_q      <= 1'b0;
      end else begin
         shift_q       <= shift_d;
         store_q       <= store_d;
         col_cnt_q     <= col_cnt_d;
         row_valid_q   <= row_valid_d;
         row_addr_q    <= row_addr_d;
         last_addr_q   <= last_addr_d;
         frame_done_q  <= frame_done_d;
         frame_cnt_q   <= frame_cnt_d;
         err_short_q   <= err_short_d;
         err_overrun_q <= err_overrun_d;
         err_oe_q      <= err_oe_d;
      end
   end

   // Read port: column 0 is the oldest pixel, stored at the far end
   assign rd_idx = COL_W'(COLS - 1) - rd_col;

   always_comb begin
      rd_pixel = '0;
      if (32'(rd_col) < COLS) rd_pixel = store_q[rd_idx];
   end

   assign row_valid   = row_valid_q;
   assign row_addr    = row_addr_q;
   assign frame_done  = frame_done_q;
   assign frame_count = frame_cnt_q;
   assign err_short   = err_short_q;
   assign err_overrun = err_overrun_q;
   assign err_oe      = err_oe_q;

endmodule

// File: tb/tb_hub75_row_monitor.sv
// Directed bench for hub75_row_monitor; a second small instance covers
// frame counter wrap cheaply.
module tb_hub75_row_monitor;
   import hub75_pkg::*;

   logic       clk = 1'b0;
   logic       nreset;
   logic       sclk, lat, oe_n;
   logic [4:0] addr;
   logic [5:0] rgb;
   logic [5:0] rd_col;
   logic [5:0] rd_pixel;
   logic       row_valid, frame_done, err_short, err_overrun, err_oe;
   logic [4:0] row_addr;
   logic [15:0] frame_count;

   logic       s_sclk, s_lat;
   logic [0:0] s_addr, s_rd_col, s_row_addr;
   logic [5:0] s_rgb, s_rd_pixel;
   logic       s_row_valid, s_frame_done, s_err_short, s_err_overrun, s_err_oe;
   logic [1:0] s_frame_count;

   int n_checks = 0;
   int n_fail   = 0;
   int fd_seen;

   always #5 clk = ~clk;

   hub75_row_monitor #(.COLS(64), .ROW_ADDR_W(5), .FRAME_CNT_W(16)) dut (
      .clk(clk), .nreset(nreset), .sclk(sclk), .lat(lat), .oe_n(oe_n),
      .addr(addr), .rgb(rgb), .rd_col(rd_col), .rd_pixel(rd_pixel),
      .row_valid(row_valid), .row_addr(row_addr), .frame_done(frame_done),
      .frame_count(frame_count), .err_short(err_short),
      .err_overrun(err_overrun), .err_oe(err_oe)
   );

   hub75_row_monitor #(.COLS(2), .ROW_ADDR_W(1), .FRAME_CNT_W(2)) u_small (
      .clk(clk), .nreset(nreset), .sclk(s_sclk), .lat(s_lat), .oe_n(1'b1),
      .addr(s_addr), .rgb(s_rgb), .rd_col(s_rd_col), .rd_pixel(s_rd_pixel),
      .row_valid(s_row_valid), .row_addr(s_row_addr), .frame_done(s_frame_done),
      .frame_count(s_frame_count), .err_short(s_err_short),
      .err_overrun(s_err_overrun), .err_oe(s_err_oe)
   );

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic [5:0] p);
      rgb  = p;
      sclk = 1'b1;
      cyc();
      sclk = 1'b0;
      cyc();
   endtask

   task automatic lat_hi(input logic [4:0] a, input logic oe);
      addr = a;
      oe_n = oe;
      lat  = 1'b1;
      cyc();
   endtask

   task automatic lat_lo();
      lat  = 1'b0;
      oe_n = 1'b1;
      cyc();
   endtask

   task automatic chk_px(input string tag, input int c, input logic [5:0] exp);
      rd_col = 6'(c);
      #1;
      chk(tag, 32'(rd_pixel), 32'(exp));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_row_valid"},   32'(row_valid),   32'd0);
      chk({tag, "_row_addr"},    32'(row_addr),    32'd0);
      chk({tag, "_frame_done"},  32'(frame_done),  32'd0);
      chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
      chk({tag, "_err_short"},   32'(err_short),   32'd0);
      chk({tag, "_err_overrun"}, 32'(err_overrun), 32'd0);
      chk({tag, "_err_oe"},      32'(err_oe),      32'd0);
      chk({tag, "_s_err_short"}, 32'(s_err_short), 32'd0);
   endtask

   initial begin
      nreset = 1'b0; sclk = 1'b0; lat = 1'b0; oe_n = 1'b1; addr = '0;
      rgb = '0; rd_col = '0;
      s_sclk = 1'b0; s_lat = 1'b0; s_addr = '0; s_rgb = '0; s_rd_col = '0;

      // Reset with sclk toggling, release with sclk high
      repeat (4) begin
         sclk = ~sclk;
         cyc();
      end
      chk_idle("rst");
      chk_px("rst_px0", 0, 6'h00);
      sclk   = 1'b1;
      nreset = 1'b1;
      cyc();
      cyc();
      chk("rst_release_no_shift", 32'(dut.col_cnt_q), 32'd0);
      sclk = 1'b0;
      cyc();

      // Nominal row
      for (int k = 0; k < 64; k++) pulse(6'(k));
      chk("nom_cnt64", 32'(dut.col_cnt_q), 32'd64);
      chk("nom_pre_valid", 32'(row_valid), 32'd0);
      lat_hi(5'd3, 1'b1);
      chk("nom_row_valid", 32'(row_valid), 32'd1);
      chk("nom_row_addr", 32'(row_addr), 32'd3);
      lat_lo();
      chk("nom_valid_pulse", 32'(row_valid), 32'd0);
      for (int k = 0; k < 64; k++) chk_px("nom_px", k, 6'(k));
      chk("nom_err_short", 32'(err_short), 32'd0);
      chk("nom_err_overrun", 32'(err_overrun), 32'd0);
      chk("nom_err_oe", 32'(err_oe), 32'd0);

      // Short row: 63 pulses, oldest slot keeps last pixel of previous row
      for (int k = 0; k < 63; k++) pulse(6'(k + 10));
      lat_hi(5'd5, 1'b1);
      lat_lo();
      chk("short_err_short", 32'(err_short), 32'd1);
      chk("short_err_overrun", 32'(err_overrun), 32'd0);
      chk_px("short_px0", 0, 6'd63);
      chk_px("short_px1", 1, 6'd10);
      chk_px("short_px63", 63, 6'd8);

      // Overrun row: 65 pulses
      for (int k = 0; k < 64; k++) pulse(6'(k) ^ 6'h2A);
      chk("ovr_at_cols", 32'(err_overrun), 32'd0);
      pulse(6'h2A);
      chk("ovr_err_overrun", 32'(err_overrun), 32'd1);
      lat_hi(5'd6, 1'b1);
      lat_lo();
      chk("ovr_row_addr", 32'(row_addr), 32'd6);
      chk_px("ovr_px0", 0, 6'h2B);
      chk_px("ovr_px63", 63, 6'h2A);
      chk("ovr_short_sticky", 32'(err_short), 32'd1);
      chk("ovr_overrun_sticky", 32'(err_overrun), 32'd1);
      chk("ovr_cnt_cleared", 32'(dut.col_cnt_q), 32'd0);

      // OE violation during latch
      for (int k = 0; k < 64; k++) pulse(make_pixel(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
      lat_hi(5'd7, 1'b0);
      chk("oe_err_oe", 32'(err_oe), 32'd1);
      chk("oe_row_valid", 32'(row_valid), 32'd1);
      chk("oe_row_addr", 32'(row_addr), 32'd7);
      lat_lo();
      chk_px("oe_px10", 10, 6'h15);

      // Frame wrap: rows 0..31 then row 0
      fd_seen = 0;
      for (int a = 0; a < 32; a++) begin
         lat_hi(5'(a), 1'b1);
         if (frame_done === 1'b1) fd_seen++;
         lat_lo();
      end
      chk("frame_none_early", 32'(fd_seen), 32'd0);
      chk("frame_cnt_early", 32'(frame_count), 32'd0);
      lat_hi(5'd0, 1'b1);
      chk("frame_done_final", 32'(frame_done), 32'd1);
      chk("frame_cnt_1", 32'(frame_count), 32'd1);
      lat_lo();
      chk("frame_done_pulse", 32'(frame_done), 32'd0);

      // Small instance: 2-bit frame counter wraps after four frames
      for (int f = 1; f <= 4; f++) begin
         if (f > 1) begin
            s_addr = 1'b1; s_lat = 1'b1; cyc();
            chk("small_no_frame", 32'(s_frame_done), 32'd0);
            s_lat = 1'b0; cyc();
         end
         s_addr = 1'b0; s_lat = 1'b1; cyc();
         chk("small_frame_done", 32'(s_frame_done), 32'd1);
         chk("small_frame_cnt", 32'(s_frame_count), 32'(f % 4));
         s_lat = 1'b0; cyc();
      end
      chk("small_err_short", 32'(s_err_short), 32'd1);

      // Fresh reset, then simultaneous sclk/lat after 63 pulses
      nreset = 1'b0;
      cyc();
      nreset = 1'b1;
      cyc();
      for (int k = 0; k < 63; k++) pulse(6'(k));
      rgb  = 6'h3F;
      addr = 5'd9;
      sclk = 1'b1;
      lat  = 1'b1;
      cyc();
      chk("sim_row_valid", 32'(row_valid), 32'd1);
      chk("sim_row_addr", 32'(row_addr), 32'd9);
      chk("sim_cnt_zero", 32'(dut.col_cnt_q), 32'd0);
      chk("sim_no_short", 32'(err_short), 32'd0);
      chk("sim_no_overrun", 32'(err_overrun), 32'd0);
      chk("sim_no_frame", 32'(frame_done), 32'd0);
      sclk = 1'b0;
      lat  = 1'b0;
      cyc();
      chk_px("sim_px0", 0, 6'd0);
      chk_px("sim_px62", 62, 6'd62);
      chk_px("sim_px63", 63, 6'h3F);

      // Asynchronous reset mid-row
      for (int k = 0; k < 5; k++) pulse(6'h11);
      sclk = 1'b1;
      #2;
      nreset = 1'b0;
      #1;
      chk_idle("midrst");
      chk_px("midrst_px63", 63, 6'h00);
      chk("midrst_cnt", 32'(dut.col_cnt_q), 32'd0);
      chk("midrst_small_cnt", 32'(s_frame_count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
